// File: rtl/gpio_cfg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gpio_cfg_pkg
// Per-pad config byte field layout, drive-mode constants and sequencer states.
// Revision: 1.0
// ----------------------------------------------------------------------------
package gpio_cfg_pkg;

   localparam int DM_LSB      = 0;
   localparam int INP_DIS_BIT = 3;
   localparam int IB_MODE_BIT = 4;
   localparam int VTRIP_BIT   = 5;
   localparam int SLOW_BIT    = 6;

   localparam logic [2:0] DM_INPUT  = 3'b001;
   localparam logic [2:0] DM_STRONG = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SLOT = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/gpio_cfg_shadow.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gpio_cfg_shadow
// NUM_PADS x 8 shadow config array; out-of-range writes are dropped and flagged.
// Revision: 1.0
// ----------------------------------------------------------------------------
module gpio_cfg_shadow
   import gpio_cfg_pkg::*;
#(
   parameter int          NUM_PADS  = 44,
   parameter int          PAD_IDX_W = 6,
   parameter logic [7:0]  RST_CFG   = 8'b0000_0001
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_wr_en,
   input  logic [PAD_IDX_W-1:0] i_wr_pad,
   input  logic [7:0]           i_wr_data,
   input  logic [PAD_IDX_W-1:0] i_rd_pad,
   output logic [7:0]           o_rd_data,
   output logic                 o_wr_err
);

   // One extra bit so NUM_PADS itself is representable even when it equals 2**PAD_IDX_W.
   localparam logic [PAD_IDX_W:0] c_num_pads = (PAD_IDX_W+1)'(NUM_PADS);

   logic [7:0] r_shadow [NUM_PADS];
   logic       r_wr_err;
   logic       w_in_range;

   assign w_in_range = ({1'b0, i_wr_pad} < c_num_pads);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PADS; i++) begin
            r_shadow[i] <= RST_CFG;
         end
         r_wr_err <= 1'b0;
      end else begin
         r_wr_err <= i_wr_en && !w_in_range;
         if (i_wr_en && w_in_range) begin
            r_shadow[i_wr_pad] <= i_wr_data;
         end
      end
   end

   assign o_rd_data = r_shadow[i_rd_pad];
   assign o_wr_err  = r_wr_err;

endmodule
`default_nettype wire

// File: rtl/gpio_pad_cfg_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gpio_pad_cfg_sequencer
// Applies shadow pad config to live outputs one pad per slot with OEB forced.
// Option: GPIO_CFG_SKIP_UNCHANGED_EN gives unchanged pads a 1-cycle, unforced slot.
// Revision: 1.0
// ----------------------------------------------------------------------------
module gpio_pad_cfg_sequencer
   import gpio_cfg_pkg::*;
#(
   parameter int          NUM_PADS    = 44,
   parameter int          PAD_IDX_W   = 6,
   parameter int          STEP_CYCLES = 4,
   parameter logic [7:0]  RST_CFG     = 8'b0000_0001
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 cfg_wr_valid,
   output logic                 cfg_wr_ready,
   input  logic [PAD_IDX_W-1:0] cfg_wr_pad,
   input  logic [7:0]           cfg_wr_data,
   output logic                 cfg_wr_err,
   input  logic                 apply_req,
   output logic                 apply_busy,
   output logic                 apply_done,
   output logic [NUM_PADS-1:0]  gpio_dm2,
   output logic [NUM_PADS-1:0]  gpio_dm1,
   output logic [NUM_PADS-1:0]  gpio_dm0,
   output logic [NUM_PADS-1:0]  gpio_inp_dis,
   output logic [NUM_PADS-1:0]  gpio_ib_mode_sel,
   output logic [NUM_PADS-1:0]  gpio_vtrip_sel,
   output logic [NUM_PADS-1:0]  gpio_slow_sel,
   output logic [NUM_PADS-1:0]  cfg_oeb_force
);

   localparam int                   c_STEP_W    = $clog2(STEP_CYCLES);
   localparam logic [c_STEP_W-1:0]  c_last_step = c_STEP_W'(STEP_CYCLES-1);
   localparam logic [PAD_IDX_W-1:0] c_last_pad  = PAD_IDX_W'(NUM_PADS-1);

   seq_state_e           r_state, w_state_nxt;
   logic [PAD_IDX_W-1:0] r_pad, w_pad_nxt;
   logic [c_STEP_W-1:0]  r_step, w_step_nxt;
   logic [7:0]           r_live [NUM_PADS];
   logic [7:0]           w_shadow_rd;
   logic                 w_load, w_force_en, w_slot_end, w_wr_acc;
   logic [NUM_PADS-1:0]  w_rsvd_unused;

   assign cfg_wr_ready = (r_state == ST_IDLE);
   assign apply_busy   = (r_state != ST_IDLE);
   assign apply_done   = (r_state == ST_DONE);
   assign w_wr_acc     = cfg_wr_valid && cfg_wr_ready;

   gpio_cfg_shadow #(
      .NUM_PADS  (NUM_PADS),
      .PAD_IDX_W (PAD_IDX_W),
      .RST_CFG   (RST_CFG)
   ) u_shadow (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .i_wr_en   (w_wr_acc),
      .i_wr_pad  (cfg_wr_pad),
      .i_wr_data (cfg_wr_data),
      .i_rd_pad  (r_pad),
      .o_rd_data (w_shadow_rd),
      .o_wr_err  (cfg_wr_err)
   );

`ifdef GPIO_CFG_SKIP_UNCHANGED_EN
   logic w_unchanged;
   assign w_unchanged = (w_shadow_rd == r_live[r_pad]);
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
         r_pad   <= '0;
         r_step  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pad   <= w_pad_nxt;
         r_step  <= w_step_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pad_nxt   = r_pad;
      w_step_nxt  = r_step;
      w_load      = 1'b0;
      w_force_en  = 1'b0;
      w_slot_end  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (apply_req) begin
               w_state_nxt = ST_SLOT;
               w_pad_nxt   = '0;
               w_step_nxt  = '0;
            end
         end
         ST_SLOT: begin
            w_load     = (r_step == '0);
            w_force_en = 1'b1;
            w_slot_end = (r_step == c_last_step);
`ifdef GPIO_CFG_SKIP_UNCHANGED_EN
            if (w_load && w_unchanged) begin
               w_force_en = 1'b0;
               w_slot_end = 1'b1;
            end
`endif
            if (w_slot_end) begin
               w_step_nxt = '0;
               if (r_pad == c_last_pad) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_pad_nxt = r_pad + PAD_IDX_W'(1);
               end
            end else begin
               w_step_nxt = r_step + c_STEP_W'(1);
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Only the pad owning the current slot is ever loaded.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < NUM_PADS; i++) begin
            r_live[i] <= RST_CFG;
         end
      end else if (w_load) begin
         r_live[r_pad] <= w_shadow_rd;
      end
   end

   for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
      assign gpio_dm0[i]         = r_live[i][DM_LSB];
      assign gpio_dm1[i]         = r_live[i][DM_LSB+1];
      assign gpio_dm2[i]         = r_live[i][DM_LSB+2];
      assign gpio_inp_dis[i]     = r_live[i][INP_DIS_BIT];
      assign gpio_ib_mode_sel[i] = r_live[i][IB_MODE_BIT];
      assign gpio_vtrip_sel[i]   = r_live[i][VTRIP_BIT];
      assign gpio_slow_sel[i]    = r_live[i][SLOW_BIT];
      assign cfg_oeb_force[i]    = w_force_en && (r_pad == PAD_IDX_W'(i));
      assign w_rsvd_unused[i]    = r_live[i][7];
   end

endmodule
`default_nettype wire

// File: tb/tb_gpio_pad_cfg_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gpio_pad_cfg_sequencer
// Self-checking bench: vector table, hand sequences and randomized sweeps.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_gpio_pad_cfg_sequencer;
   import gpio_cfg_pkg::*;

   localparam int         NP  = 44;
   localparam int         IW  = 6;
   localparam int         SC  = 4;
   localparam logic [7:0] RST = 8'b0000_0001;
`ifdef GPIO_CFG_SKIP_UNCHANGED_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, wr_valid, apply_req;
   logic [IW-1:0] wr_pad;
   logic [7:0]    wr_data;
   logic          wr_ready, wr_err, busy, done;
   logic [NP-1:0] dm2, dm1, dm0, inp_dis, ib_mode, vtrip, slow, force_oeb;

   gpio_pad_cfg_sequencer #(
      .NUM_PADS(NP), .PAD_IDX_W(IW), .STEP_CYCLES(SC), .RST_CFG(RST)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cfg_wr_valid(wr_valid), .cfg_wr_ready(wr_ready), .cfg_wr_pad(wr_pad),
      .cfg_wr_data(wr_data), .cfg_wr_err(wr_err),
      .apply_req(apply_req), .apply_busy(busy), .apply_done(done),
      .gpio_dm2(dm2), .gpio_dm1(dm1), .gpio_dm0(dm0), .gpio_inp_dis(inp_dis),
      .gpio_ib_mode_sel(ib_mode), .gpio_vtrip_sel(vtrip), .gpio_slow_sel(slow),
      .cfg_oeb_force(force_oeb)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] mdl_shadow [NP];
   logic [7:0] mdl_live   [NP];
   logic [7:0] exp_live   [NP];
   int         st [NP+1];
   int         ln [NP];
   bit         frc [NP];

   typedef struct {
      logic [IW-1:0] pad;
      logic [7:0]    data;
      logic          exp_err;
   } wr_vec_t;

   task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s k=%0d actual=%0h expected=%0h", name, k, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NP-1:0] fld(input int b);
      logic [NP-1:0] v;
      for (int q = 0; q < NP; q++) v[q] = exp_live[q][b];
      return v;
   endfunction

   task automatic check_live(input string tag, input int k);
      chk({tag, "_dm0"},   k, dm0,     fld(0));
      chk({tag, "_dm1"},   k, dm1,     fld(1));
      chk({tag, "_dm2"},   k, dm2,     fld(2));
      chk({tag, "_inpdis"},k, inp_dis, fld(3));
      chk({tag, "_ibmode"},k, ib_mode, fld(4));
      chk({tag, "_vtrip"}, k, vtrip,   fld(5));
      chk({tag, "_slow"},  k, slow,    fld(6));
   endtask

   task automatic check_idle(input string tag, input int k);
      chk({tag, "_busy"},  k, busy,      0);
      chk({tag, "_done"},  k, done,      0);
      chk({tag, "_ready"}, k, wr_ready,  1);
      chk({tag, "_force"}, k, force_oeb, 0);
      for (int q = 0; q < NP; q++) exp_live[q] = mdl_live[q];
      check_live(tag, k);
   endtask

   task automatic do_write(input logic [IW-1:0] pad, input logic [7:0] data, input logic exp_err);
      wr_valid = 1'b1;
      wr_pad   = pad;
      wr_data  = data;
      chk("wr_ready", 0, wr_ready, 1);
      tick();
      wr_valid = 1'b0;
      if (pad < NP) mdl_shadow[pad] = data;
      chk("wr_err", 0, wr_err, exp_err);
   endtask

   // Slot plan: changed pads (or every pad without skipping) take SC forced cycles.
   task automatic schedule();
      st[0] = 0;
      for (int p = 0; p < NP; p++) begin
         if (SKIP && mdl_shadow[p] == mdl_live[p]) begin
            ln[p] = 1; frc[p] = 1'b0;
         end else begin
            ln[p] = SC; frc[p] = 1'b1;
         end
         st[p+1] = st[p] + ln[p];
      end
   endtask

   // k counts samples after the edge that accepted apply_req.
   task automatic run_sweep(input int pulse_at, input int rst_at, input bit co_wr,
                            input logic [IW-1:0] co_pad, input logic [7:0] co_data);
      logic [7:0]    old [NP];
      logic [NP-1:0] ef;
      int            done_k;
      apply_req = 1'b1;
      wr_valid  = co_wr;
      wr_pad    = co_pad;
      wr_data   = co_data;
      tick();
      apply_req = 1'b0;
      wr_valid  = 1'b0;
      if (co_wr && co_pad < NP) mdl_shadow[co_pad] = co_data;
      schedule();
      done_k = st[NP];
      for (int q = 0; q < NP; q++) old[q] = mdl_live[q];
      for (int k = 0; k <= done_k; k++) begin
         if (k == rst_at) begin
            rst = 1'b0;
            for (int q = 0; q < NP; q++) begin
               mdl_shadow[q] = RST;
               mdl_live[q]   = RST;
            end
            check_idle("rst_abort", k);
            chk("rst_abort_err", k, wr_err, 0);
            tick();
            chk("rst_abort_nodone1", k + 1, done, 0);
            tick();
            chk("rst_abort_nodone2", k + 2, done, 0);
            chk("rst_abort_busy", k + 2, busy, 0);
            return;
         end
         for (int q = 0; q < NP; q++) begin
            exp_live[q] = (k >= st[q] + 1) ? mdl_shadow[q] : old[q];
            ef[q]       = frc[q] && (k >= st[q]) && (k < st[q] + ln[q]);
         end
         chk("sweep_force", k, force_oeb, ef);
         chk("sweep_busy",  k, busy, 1);
         chk("sweep_done",  k, done, (k == done_k));
         chk("sweep_ready", k, wr_ready, 0);
         chk("sweep_err",   k, wr_err, (k == 0 && co_wr && co_pad >= NP));
         check_live("sweep", k);
         apply_req = (k + 1 == pulse_at);
         wr_valid  = (k + 1 == pulse_at);
         wr_pad    = 7;
         wr_data   = 8'h5A;
         if (k + 1 == rst_at) rst = 1'b1;
         tick();
      end
      apply_req = 1'b0;
      wr_valid  = 1'b0;
      for (int q = 0; q < NP; q++) mdl_live[q] = mdl_shadow[q];
      check_idle("post_sweep", done_k + 1);
   endtask

   wr_vec_t vecs [8];

   initial begin
      int n;
      rst = 1'b1; wr_valid = 1'b0; apply_req = 1'b0; wr_pad = '0; wr_data = '0;
      for (int q = 0; q < NP; q++) begin
         mdl_shadow[q] = RST;
         mdl_live[q]   = RST;
      end
      tick();
      tick();
      check_idle("reset", 0);
      chk("reset_err", 0, wr_err, 0);
      chk("reset_dm_input", 0, {dm2[0], dm1[0], dm0[0]}, DM_INPUT);
      rst = 1'b0;
      tick();

      // Out-of-range write is dropped; sweep leaves everything at reset config.
      do_write(6'd50, 8'hFF, 1'b1);
      tick();
      chk("err_one_pulse", 0, wr_err, 0);
      run_sweep(-1, -1, 1'b0, '0, '0);

      // Pad 5 to strong drive, with an ignored apply/write pulse mid-sweep.
      do_write(6'd5, {5'b0, DM_STRONG}, 1'b0);
      run_sweep(10, -1, 1'b0, '0, '0);

      vecs[0] = '{pad: 6'd5,  data: 8'h06, exp_err: 1'b0};
      vecs[1] = '{pad: 6'd50, data: 8'hAA, exp_err: 1'b1};
      vecs[2] = '{pad: 6'd43, data: 8'hC1, exp_err: 1'b0};
      vecs[3] = '{pad: 6'd0,  data: 8'h7E, exp_err: 1'b0};
      vecs[4] = '{pad: 6'd44, data: 8'hFF, exp_err: 1'b1};
      vecs[5] = '{pad: 6'd20, data: 8'h38, exp_err: 1'b0};
      vecs[6] = '{pad: 6'd63, data: 8'h00, exp_err: 1'b1};
      vecs[7] = '{pad: 6'd1,  data: 8'h80, exp_err: 1'b0};
      for (int i = 0; i < 8; i++) begin
         do_write(vecs[i].pad, vecs[i].data, vecs[i].exp_err);
         check_idle("tbl_pre", i);
      end
      run_sweep(-1, -1, 1'b0, '0, '0);

      // Write in the same cycle as apply_req lands in this sweep.
      run_sweep(-1, -1, 1'b1, 6'd0, 8'h4B);

      // Reset mid-sweep.
      for (int q = 0; q < 10; q++) do_write(IW'(q), mdl_shadow[q] ^ 8'h10, 1'b0);
      run_sweep(-1, 30, 1'b0, '0, '0);

      // apply_req held high: restart one cycle after done.
      do_write(6'd3, mdl_shadow[3] ^ 8'h20, 1'b0);
      apply_req = 1'b1;
      tick();
      schedule();
      n = 0;
      while (!done && n < 2000) begin
         tick();
         n++;
      end
      chk("held_done_k", 0, n, st[NP]);
      for (int q = 0; q < NP; q++) mdl_live[q] = mdl_shadow[q];
      tick();
      chk("held_gap_busy", 0, busy, 0);
      tick();
      chk("held_restart_busy", 0, busy, 1);
      chk("held_restart_force0", 0, force_oeb[0], !SKIP);
      apply_req = 1'b0;
      n = 0;
      while (!done && n < 2000) begin
         tick();
         n++;
      end
      chk("held_second_done", 0, done, 1);
      tick();
      check_idle("held_end", 0);

      for (int r = 0; r < 6; r++) begin
         int nw;
         nw = $urandom_range(1, 6);
         for (int w = 0; w < nw; w++) begin
            logic [IW-1:0] p;
            logic [7:0]    d;
            p = IW'($urandom_range(0, 63));
            d = 8'($urandom);
            if (p < NP && $urandom_range(0, 3) == 0) d = mdl_shadow[p];
            do_write(p, d, (p >= NP));
         end
         repeat ($urandom_range(0, 3)) begin
            tick();
            check_idle("rnd_gap", r);
         end
         run_sweep($urandom_range(1, 20), -1, 1'($urandom_range(0, 1)),
                   IW'($urandom_range(0, 50)), 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
